// File: rtl/decode_issue_if.sv
// Decode/issue interface bundle: fetch handshake, register file reads,
// execute-side output register, writeback notification and scoreboard view.
interface decode_issue_if #(
   parameter int unsigned NREG = 64,
   parameter int unsigned AW   = 6
);
   logic            in_valid;
   logic            in_ready;
   logic [31:0]     in_inst;
   logic [AW-1:0]   rf_raddr1;
   logic [AW-1:0]   rf_raddr2;
   logic [AW-1:0]   rf_raddr_d;
   logic [31:0]     rf_rdata1;
   logic [31:0]     rf_rdata2;
   logic [31:0]     rf_rdata_d;
   logic            out_valid;
   logic            out_ready;
   logic            out_en;
   logic            out_imm;
   logic            out_mov;
   logic [3:0]      out_funct;
   logic [7:0]      out_src1;
   logic [7:0]      out_src2;
   logic [31:0]     out_read1;
   logic [31:0]     out_read2;
   logic [31:0]     out_read_dest;
   logic [AW-1:0]   out_dest;
   logic            wb_valid;
   logic [AW-1:0]   wb_addr;
   logic [NREG-1:0] busy;

   // Decode stage side
   modport slave (
      input  in_valid, in_inst, rf_rdata1, rf_rdata2, rf_rdata_d, out_ready, wb_valid, wb_addr,
      output in_ready, rf_raddr1, rf_raddr2, rf_raddr_d, out_valid, out_en, out_imm, out_mov,
             out_funct, out_src1, out_src2, out_read1, out_read2, out_read_dest, out_dest, busy
   );

   // Fetch / register file / execute / writeback side
   modport master (
      output in_valid, in_inst, rf_rdata1, rf_rdata2, rf_rdata_d, out_ready, wb_valid, wb_addr,
      input  in_ready, rf_raddr1, rf_raddr2, rf_raddr_d, out_valid, out_en, out_imm, out_mov,
             out_funct, out_src1, out_src2, out_read1, out_read2, out_read_dest, out_dest, busy
   );
endinterface

// File: rtl/decode_issue.sv
// Decode/issue stage: decodes fetch instructions, reads operands, stalls on
// scoreboard hazards and holds one output register toward execute.
module decode_issue #(
   parameter int unsigned NREG = 64,
   parameter int unsigned AW   = 6
) (
   input logic          clk,
   input logic          rstn,
   decode_issue_if.slave bus
);
   logic          imm, mov, en;
   logic [3:0]    funct;
   logic [AW-1:0] dest, rs1, rs2;
   logic [7:0]    src1, src2;
   logic          need1, need2, needd;
   logic          hazard, accept;

   logic [NREG-1:0] busy_q, busy_d;
   logic            out_valid_q, out_valid_d;
   logic            en_q, en_d, imm_q, imm_d, mov_q, mov_d;
   logic [3:0]      funct_q, funct_d;
   logic [7:0]      src1_q, src1_d, src2_q, src2_d;
   logic [31:0]     read1_q, read1_d, read2_q, read2_d, readd_q, readd_d;
   logic [AW-1:0]   dest_q, dest_d;

   // Bits 19:16 carry no field
   logic unused_inst;
   assign unused_inst = ^bus.in_inst[19:16];

   // Field decode, operand needs and hazard detection
   always_comb begin
      imm   = bus.in_inst[31];
      mov   = bus.in_inst[30];
      funct = bus.in_inst[29:26];
      dest  = bus.in_inst[25:20];
      src1  = bus.in_inst[15:8];
      src2  = bus.in_inst[7:0];
      rs1   = src1[AW-1:0];
      rs2   = src2[AW-1:0];
      en    = (funct != 4'd0);
      need1 = 1'b0;
      need2 = 1'b0;
      needd = 1'b0;
      // NOPs read nothing, so their operand fields load as zero
      if (en) begin
         if (!imm) begin
            need1 = 1'b1;
            need2 = 1'b1;
         end else if (!mov) begin
            need1 = 1'b1;
         end else if (funct[1]) begin
            needd = 1'b1;
         end
      end
      // Scoreboard is read from the register only; no writeback bypass
      hazard = bus.in_valid && en &&
               ((need1 && busy_q[rs1]) || (need2 && busy_q[rs2]) || busy_q[dest]);
      bus.in_ready   = !hazard && (!out_valid_q || bus.out_ready);
      accept         = bus.in_valid && bus.in_ready;
      bus.rf_raddr1  = rs1;
      bus.rf_raddr2  = rs2;
      bus.rf_raddr_d = dest;
   end

   // Next-state for output register and scoreboard
   always_comb begin
      out_valid_d = out_valid_q;
      en_d        = en_q;
      imm_d       = imm_q;
      mov_d       = mov_q;
      funct_d     = funct_q;
      src1_d      = src1_q;
      src2_d      = src2_q;
      read1_d     = read1_q;
      read2_d     = read2_q;
      readd_d     = readd_q;
      dest_d      = dest_q;
      busy_d      = busy_q;
      if (accept) begin
         out_valid_d = 1'b1;
         en_d        = en;
         imm_d       = imm;
         mov_d       = mov;
         funct_d     = funct;
         src1_d      = src1;
         src2_d      = src2;
         read1_d     = need1 ? bus.rf_rdata1 : 32'd0;
         read2_d     = need2 ? bus.rf_rdata2 : 32'd0;
         readd_d     = needd ? bus.rf_rdata_d : 32'd0;
         dest_d      = dest;
      end else if (out_valid_q && bus.out_ready) begin
         out_valid_d = 1'b0;
      end
      if (bus.wb_valid) begin
         busy_d[bus.wb_addr] = 1'b0;
      end
      // Set after clear so a same-index collision leaves the register busy
      if (accept && en) begin
         busy_d[dest] = 1'b1;
      end
   end

   // State registers, cleared asynchronously
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         out_valid_q <= 1'b0;
         en_q        <= 1'b0;
         imm_q       <= 1'b0;
         mov_q       <= 1'b0;
         funct_q     <= 4'd0;
         src1_q      <= 8'd0;
         src2_q      <= 8'd0;
         read1_q     <= 32'd0;
         read2_q     <= 32'd0;
         readd_q     <= 32'd0;
         dest_q      <= '0;
         busy_q      <= '0;
      end else begin
         out_valid_q <= out_valid_d;
         en_q        <= en_d;
         imm_q       <= imm_d;
         mov_q       <= mov_d;
         funct_q     <= funct_d;
         src1_q      <= src1_d;
         src2_q      <= src2_d;
         read1_q     <= read1_d;
         read2_q     <= read2_d;
         readd_q     <= readd_d;
         dest_q      <= dest_d;
         busy_q      <= busy_d;
      end
   end

   // Output register drive
   always_comb begin
      bus.out_valid     = out_valid_q;
      bus.out_en        = en_q;
      bus.out_imm       = imm_q;
      bus.out_mov       = mov_q;
      bus.out_funct     = funct_q;
      bus.out_src1      = src1_q;
      bus.out_src2      = src2_q;
      bus.out_read1     = read1_q;
      bus.out_read2     = read2_q;
      bus.out_read_dest = readd_q;
      bus.out_dest      = dest_q;
      bus.busy          = busy_q;
   end
endmodule

// File: tb/tb_decode_issue.sv
// Directed self-checking bench for decode_issue.
module tb_decode_issue;
   logic clk;
   logic rstn;
   int   nvec;
   int   nerr;

   decode_issue_if #(.NREG(64), .AW(6)) bus ();

   decode_issue #(.NREG(64), .AW(6)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] mk(input logic imm, input logic mov, input logic [3:0] funct,
                                      input logic [5:0] dest, input logic [7:0] s1,
                                      input logic [7:0] s2);
      return {imm, mov, funct, dest, 4'b0000, s1, s2};
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rstn = 1'b0;
      bus.in_valid = 1'b0; bus.in_inst = 32'd0; bus.out_ready = 1'b1;
      bus.rf_rdata1 = 32'd0; bus.rf_rdata2 = 32'd0; bus.rf_rdata_d = 32'd0;
      bus.wb_valid = 1'b0; bus.wb_addr = 6'd0;
      #12;
      nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL reset_valid: got %h want 0", bus.out_valid); end
      nvec++; if (bus.busy !== 64'd0) begin nerr++; $display("FAIL reset_busy: got %h want 0", bus.busy); end
      nvec++; if (bus.out_read1 !== 32'd0) begin nerr++; $display("FAIL reset_read1: got %h want 0", bus.out_read1); end
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL reset_ready: got %h want 1", bus.in_ready); end
      @(negedge clk);
      rstn = 1'b1;
   endtask

   task automatic test_basic();
      step();
      bus.in_inst = mk(1'b0, 1'b0, 4'd1, 6'd3, 8'd1, 8'd2);
      bus.rf_rdata1 = 32'd5; bus.rf_rdata2 = 32'd7; bus.in_valid = 1'b1;
      #1;
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL basic_ready: got %h want 1", bus.in_ready); end
      nvec++; if (bus.rf_raddr1 !== 6'd1) begin nerr++; $display("FAIL basic_raddr1: got %h want 1", bus.rf_raddr1); end
      nvec++; if (bus.rf_raddr2 !== 6'd2) begin nerr++; $display("FAIL basic_raddr2: got %h want 2", bus.rf_raddr2); end
      nvec++; if (bus.rf_raddr_d !== 6'd3) begin nerr++; $display("FAIL basic_raddr_d: got %h want 3", bus.rf_raddr_d); end
      step();
      bus.in_valid = 1'b0;
      nvec++; if (bus.out_valid !== 1'b1) begin nerr++; $display("FAIL basic_valid: got %h want 1", bus.out_valid); end
      nvec++; if (bus.out_read1 !== 32'd5) begin nerr++; $display("FAIL basic_read1: got %h want 5", bus.out_read1); end
      nvec++; if (bus.out_read2 !== 32'd7) begin nerr++; $display("FAIL basic_read2: got %h want 7", bus.out_read2); end
      nvec++; if (bus.out_dest !== 6'd3) begin nerr++; $display("FAIL basic_dest: got %h want 3", bus.out_dest); end
      nvec++; if (bus.out_en !== 1'b1 || bus.out_funct !== 4'd1) begin nerr++; $display("FAIL basic_ctrl: got en=%h funct=%h want en=1 funct=1", bus.out_en, bus.out_funct); end
      nvec++; if (bus.busy !== 64'h8) begin nerr++; $display("FAIL basic_busy: got %h want 8", bus.busy); end
   endtask

   task automatic test_raw();
      bus.in_inst = mk(1'b0, 1'b0, 4'd2, 6'd3, 8'd3, 8'd4);
      bus.rf_rdata1 = 32'h30; bus.rf_rdata2 = 32'h40; bus.in_valid = 1'b1;
      #1;
      nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL raw_stall0: got %h want 0", bus.in_ready); end
      step();
      nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL raw_stall1: got %h want 0", bus.in_ready); end
      nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL raw_drain: got %h want 0", bus.out_valid); end
      bus.wb_valid = 1'b1; bus.wb_addr = 6'd3;
      #1;
      nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL raw_nobypass: got %h want 0", bus.in_ready); end
      step();
      bus.wb_valid = 1'b0;
      #1;
      nvec++; if (bus.busy[3] !== 1'b0) begin nerr++; $display("FAIL raw_cleared: got %h want 0", bus.busy[3]); end
      nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL raw_noaccept: got %h want 0", bus.out_valid); end
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL raw_ready: got %h want 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      nvec++; if (bus.out_valid !== 1'b1 || bus.out_funct !== 4'd2) begin nerr++; $display("FAIL raw_issue: got valid=%h funct=%h want 1/2", bus.out_valid, bus.out_funct); end
      nvec++; if (bus.out_read1 !== 32'h30 || bus.out_read2 !== 32'h40) begin nerr++; $display("FAIL raw_ops: got %h/%h want 30/40", bus.out_read1, bus.out_read2); end
      nvec++; if (bus.busy !== 64'h8) begin nerr++; $display("FAIL raw_reset_busy: got %h want 8", bus.busy); end
      bus.wb_valid = 1'b1; bus.wb_addr = 6'd3;
      step();
      bus.wb_valid = 1'b0;
      nvec++; if (bus.busy !== 64'd0) begin nerr++; $display("FAIL raw_final_busy: got %h want 0", bus.busy); end
   endtask

   task automatic test_backpressure();
      bus.out_ready = 1'b0;
      bus.in_inst = mk(1'b0, 1'b0, 4'd3, 6'd5, 8'd6, 8'd7);
      bus.rf_rdata1 = 32'h11; bus.rf_rdata2 = 32'h22; bus.in_valid = 1'b1;
      step();
      bus.in_inst = mk(1'b0, 1'b0, 4'd4, 6'd8, 8'd9, 8'd10);
      bus.rf_rdata1 = 32'h33; bus.rf_rdata2 = 32'h44;
      #1;
      for (int i = 0; i < 3; i++) begin
         nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL bp_ready%0d: got %h want 0", i, bus.in_ready); end
         nvec++; if (bus.out_valid !== 1'b1 || bus.out_read1 !== 32'h11 || bus.out_dest !== 6'd5) begin nerr++; $display("FAIL bp_hold%0d: got v=%h r1=%h d=%h want 1/11/5", i, bus.out_valid, bus.out_read1, bus.out_dest); end
         step();
      end
      bus.out_ready = 1'b1; bus.wb_valid = 1'b1; bus.wb_addr = 6'd8;
      #1;
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL bp_release: got %h want 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0; bus.wb_valid = 1'b0;
      nvec++; if (bus.out_read1 !== 32'h33 || bus.out_read2 !== 32'h44 || bus.out_dest !== 6'd8) begin nerr++; $display("FAIL bp_load: got r1=%h r2=%h d=%h want 33/44/8", bus.out_read1, bus.out_read2, bus.out_dest); end
      nvec++; if (bus.busy !== 64'h120) begin nerr++; $display("FAIL bp_setwins: got %h want 120", bus.busy); end
      step();
      nvec++; if (bus.out_valid !== 1'b0 || bus.out_dest !== 6'd8) begin nerr++; $display("FAIL bp_drain: got v=%h d=%h want 0/8", bus.out_valid, bus.out_dest); end
      bus.wb_valid = 1'b1; bus.wb_addr = 6'd5;
      step();
      bus.wb_addr = 6'd8;
      step();
      bus.wb_valid = 1'b0;
      nvec++; if (bus.busy !== 64'd0) begin nerr++; $display("FAIL bp_busy_clear: got %h want 0", bus.busy); end
   endtask

   task automatic test_movh();
      bus.in_inst = mk(1'b1, 1'b1, 4'd2, 6'd4, 8'h12, 8'h34);
      bus.rf_rdata1 = 32'hdead; bus.rf_rdata2 = 32'hbeef; bus.rf_rdata_d = 32'h0000abcd;
      bus.in_valid = 1'b1;
      #1;
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL movh_ready: got %h want 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0;
      nvec++; if (bus.out_read_dest !== 32'h0000abcd) begin nerr++; $display("FAIL movh_rd: got %h want 0000abcd", bus.out_read_dest); end
      nvec++; if (bus.out_read1 !== 32'd0 || bus.out_read2 !== 32'd0) begin nerr++; $display("FAIL movh_zero: got %h/%h want 0/0", bus.out_read1, bus.out_read2); end
      nvec++; if (bus.out_imm !== 1'b1 || bus.out_mov !== 1'b1 || bus.out_src1 !== 8'h12 || bus.out_src2 !== 8'h34) begin nerr++; $display("FAIL movh_fields: got imm=%h mov=%h s1=%h s2=%h want 1/1/12/34", bus.out_imm, bus.out_mov, bus.out_src1, bus.out_src2); end
      nvec++; if (bus.busy !== 64'h10) begin nerr++; $display("FAIL movh_busy: got %h want 10", bus.busy); end
      bus.wb_valid = 1'b1; bus.wb_addr = 6'd4;
      step();
      bus.wb_valid = 1'b0;
   endtask

   task automatic test_nop();
      int stalls;
      stalls = 0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 64; i++) begin
         bus.in_inst = mk(1'b1, 1'b1, 4'd1, i[5:0], 8'd0, 8'd0);
         #1;
         if (bus.in_ready !== 1'b1) stalls++;
         step();
      end
      nvec++; if (stalls != 0) begin nerr++; $display("FAIL nop_fill_stalls: got %0d want 0", stalls); end
      nvec++; if (bus.busy !== {64{1'b1}}) begin nerr++; $display("FAIL nop_fill_busy: got %h want all ones", bus.busy); end
      bus.in_inst = mk(1'b1, 1'b1, 4'd1, 6'd0, 8'd0, 8'd0);
      #1;
      nvec++; if (bus.in_ready !== 1'b0) begin nerr++; $display("FAIL nop_nonnop_stall: got %h want 0", bus.in_ready); end
      bus.in_inst = mk(1'b0, 1'b0, 4'd0, 6'd3, 8'd1, 8'd2);
      bus.rf_rdata1 = 32'h55; bus.rf_rdata2 = 32'h66;
      #1;
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL nop_ready: got %h want 1", bus.in_ready); end
      step();
      bus.in_valid = 1'b0; bus.out_ready = 1'b0;
      nvec++; if (bus.out_valid !== 1'b1 || bus.out_en !== 1'b0) begin nerr++; $display("FAIL nop_out: got v=%h en=%h want 1/0", bus.out_valid, bus.out_en); end
      nvec++; if (bus.out_read1 !== 32'd0 || bus.out_read2 !== 32'd0) begin nerr++; $display("FAIL nop_ops: got %h/%h want 0/0", bus.out_read1, bus.out_read2); end
      nvec++; if (bus.busy !== {64{1'b1}}) begin nerr++; $display("FAIL nop_busy: got %h want all ones", bus.busy); end
   endtask

   task automatic test_async_reset();
      step();
      nvec++; if (bus.out_valid !== 1'b1 || bus.busy[3] !== 1'b1 || bus.busy[7] !== 1'b1) begin nerr++; $display("FAIL ar_pre: got v=%h b3=%h b7=%h want 1/1/1", bus.out_valid, bus.busy[3], bus.busy[7]); end
      #2;
      rstn = 1'b0;
      #1;
      nvec++; if (bus.out_valid !== 1'b0) begin nerr++; $display("FAIL ar_valid: got %h want 0", bus.out_valid); end
      nvec++; if (bus.busy !== 64'd0) begin nerr++; $display("FAIL ar_busy: got %h want 0", bus.busy); end
      nvec++; if (bus.out_dest !== 6'd0 || bus.out_funct !== 4'd0) begin nerr++; $display("FAIL ar_fields: got d=%h f=%h want 0/0", bus.out_dest, bus.out_funct); end
      nvec++; if (bus.in_ready !== 1'b1) begin nerr++; $display("FAIL ar_ready: got %h want 1", bus.in_ready); end
      @(negedge clk);
      rstn = 1'b1;
      step();
   endtask

   initial begin
      nvec = 0;
      nerr = 0;
      test_reset();
      test_basic();
      test_raw();
      test_backpressure();
      test_movh();
      test_nop();
      test_async_reset();
      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end
endmodule
